dac_spi_ctrl: RTL and testbench
===============================

Name: dac_spi_ctrl

Overview:
- Configuration controller for the main 16-bit dual-port DAC serial port (`dac_csb`, `dac_sclk`, `dac_sdio`, `dac_sdo`) and its `dac_reset` pin.
- Runs the DAC power-up reset sequence, then accepts single-byte register read/write commands over a valid/ready interface and serialises them in 4-wire SPI mode.
- Lives in the 250 MHz domain next to the DAC datapath; it replaces the tied-off `dac_*` control outputs in the top level.

Parameters:
- PRESCALE, 4: clk cycles per SCLK half-period; legal range ≥1; SCLK = f_clk/(2*PRESCALE).
- RESET_CYCLES, 64: clk cycles `dac_reset` is held high; must be ≥1.
- RESET_WAIT, 256: clk cycles after `dac_reset` falls before the first command is accepted; must be ≥1.

Ports:
- clk  in  1  DAC-domain clock (`clk_250mhz`).
- rst  in  1  Synchronous, active-high reset.
- cmd_valid  in  1  Command present.
- cmd_ready  out  1  Controller can accept a command.
- cmd_read  in  1  1 = read, 0 = write.
- cmd_addr  in  5  DAC register address.
- cmd_wdata  in  8  Write data; ignored for reads.
- rsp_valid  out  1  One-cycle pulse marking end of transaction.
- rsp_rdata  out  8  Read data; 0 after a write.
- reset_req  in  1  Request a DAC hard-reset sequence; honoured only in IDLE.
- init_done  out  1  High once the reset sequence completes; low during any reset sequence.
- dac_reset  out  1  DAC hardware reset, active high.
- dac_csb  out  1  SPI chip select, active low.
- dac_sclk  out  1  SPI clock, idles low.
- dac_sdio  out  1  SPI data to DAC.
- dac_sdo  in  1  SPI data from DAC.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Output values while `rst` is high and on the first cycle after: `dac_reset`=1, `dac_csb`=1, `dac_sclk`=0, `dac_sdio`=0, `cmd_ready`=0, `rsp_valid`=0, `rsp_rdata`=0, `init_done`=0.
- All outputs are registered.
- States: RST_ASSERT → RST_WAIT → IDLE → SHIFT → HOLD → GAP → IDLE.
- RST_ASSERT: `dac_reset`=1 for exactly RESET_CYCLES cycles.
- RST_WAIT: `dac_reset`=0 for RESET_WAIT cycles.
- On entering IDLE: `init_done`=1 and `cmd_ready`=1.
- IDLE handshake: a transaction starts on the cycle T where `cmd_valid && cmd_ready`. Inputs are captured at T and `cmd_ready` drops at T+1.
- Command word: 16 bits, MSB first.
  - bit15 = `cmd_read`
  - bits14:13 = 00 (one-byte transfer)
  - bits12:8 = `cmd_addr`
  - bits7:0 = `cmd_wdata` for a write, 0 for a read
- SHIFT, from T+1:
  - `dac_csb`=0.
  - Each bit occupies 2*PRESCALE cycles: PRESCALE cycles with `dac_sclk`=0 (`dac_sdio` set to the bit at the start), then PRESCALE cycles with `dac_sclk`=1.
  - `dac_sdo` is sampled on the cycle `dac_sclk` rises, for bits 7..0 only, into a shift register, MSB first.
- HOLD: after the bit0 high phase, `dac_sclk`=0 and `dac_csb`=0 for PRESCALE cycles.
- End of transaction, at cycle T+1+33*PRESCALE:
  - `dac_csb`=1, `dac_sdio`=0.
  - `rsp_valid`=1 for one cycle.
  - `rsp_rdata` = sampled byte for a read, 0 for a write; held until the next `rsp_valid`.
- GAP: `dac_csb`=1 for PRESCALE cycles; `cmd_ready`=1 at T+1+34*PRESCALE.
- `reset_req`:
  - In IDLE with `cmd_valid`=0: enter RST_ASSERT next cycle, dropping `init_done` and `cmd_ready`.
  - Simultaneous with `cmd_valid` in IDLE: `reset_req` wins and the command is not accepted.
  - Outside IDLE: ignored.
- `cmd_valid` while `cmd_ready`=0 is not consumed; the requester holds it.
- `rst` mid-transaction: all outputs return to reset values on the next edge, including `dac_csb` high immediately. No `rsp_valid` is produced.
- Counters are sized with `$clog2` of the largest of PRESCALE, RESET_CYCLES and RESET_WAIT. The bit counter is 4 bits and counts 15..0 with no wrap beyond 0.

Decomposition:
- Shared header `dac_spi_defs.vh`:
  - state encodings
  - command-word bit positions (RW=15, N=14:13, ADDR=12:8, DATA=7:0)
  - read/write flag constants
- One natural sub-module: `spi_phase_gen`, a PRESCALE half-period counter emitting `rise`/`fall` strobes and `sclk`.
- The FSM and shift registers stay in `dac_spi_ctrl`.

Test Plan:
- Test parameters: PRESCALE=2, RESET_CYCLES=4, RESET_WAIT=8.
- Reset sequence: release `rst` → `dac_reset`=1 for 4 cycles, then 0; `cmd_ready`=`init_done`=1 exactly 8 cycles later; `dac_csb`=1 and `dac_sclk`=0 throughout.
- Write: addr=0x02, wdata=0xA5 → MOSI word 0x02A5 sampled on 16 SCLK rises; `dac_csb` low for 66 cycles; `rsp_valid` at T+67 with `rsp_rdata`=0; `cmd_ready` back at T+69.
- Read: addr=0x1F, DAC model drives 0x3C on `dac_sdo` → MOSI word 0x9F00; `rsp_rdata`=0x3C with a single-cycle `rsp_valid`.
- Back-to-back: `cmd_valid` held with two writes → second `dac_csb` fall exactly 3 cycles after the first `dac_csb` rise; no overlap; two `rsp_valid` pulses.
- `reset_req` and `cmd_valid` in the same IDLE cycle → command not accepted; `dac_reset` pulses for 4 cycles; the command is accepted after `init_done` returns.
- Assert `rst` during bit 9 → next edge `dac_csb`=1, `dac_sclk`=0, no `rsp_valid`; full reset sequence restarts.

Source files
------------

// File: rtl/dac_spi_ctrl_pkg.sv
// Shared definitions for the DAC SPI configuration controller: FSM states,
// command-word layout and the counter sizing helpers.
package dac_spi_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_RST_ASSERT,
      ST_RST_WAIT,
      ST_IDLE,
      ST_SHIFT,
      ST_HOLD,
      ST_GAP
   } state_e;

   localparam int CMD_RW_BIT   = 15;
   localparam int CMD_N_MSB    = 14;
   localparam int CMD_N_LSB    = 13;
   localparam int CMD_ADDR_MSB = 12;
   localparam int CMD_ADDR_LSB = 8;
   localparam int CMD_DATA_MSB = 7;
   localparam int CMD_DATA_LSB = 0;

   localparam logic       CMD_WRITE      = 1'b0;
   localparam logic       CMD_READ       = 1'b1;
   localparam logic [1:0] CMD_N_ONE_BYTE = 2'b00;

   // A counter that reaches max_count-1 needs $clog2(max_count) bits, never fewer than one.
   function automatic int cnt_width(input int max_count);
      return (max_count > 1) ? $clog2(max_count) : 1;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   function automatic logic [15:0] build_cmd_word(input logic       rd,
                                                  input logic [4:0] addr,
                                                  input logic [7:0] wdata);
      logic [15:0] w;
      w                             = '0;
      w[CMD_RW_BIT]                 = rd;
      w[CMD_N_MSB:CMD_N_LSB]        = CMD_N_ONE_BYTE;
      w[CMD_ADDR_MSB:CMD_ADDR_LSB]  = addr;
      w[CMD_DATA_MSB:CMD_DATA_LSB]  = (rd == CMD_READ) ? 8'h00 : wdata;
      return w;
   endfunction

endpackage

// File: rtl/dac_spi_ctrl_phase_gen.sv
// SCLK phase generator: PRESCALE-cycle half-period counter that produces a
// registered sclk plus rise/fall strobes one cycle ahead of the sclk edge.
module spi_phase_gen
   import dac_spi_ctrl_pkg::*;
#(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic rise,
   output logic fall,
   output logic sclk
);

   localparam int            PW     = cnt_width(PRESCALE);
   localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt_q, cnt_d;
   logic          sclk_q, sclk_d;
   logic          wrap;

   // Disabling the generator parks it at the start of a low phase.
   always_comb begin
      wrap   = en && (cnt_q == P_LAST);
      cnt_d  = '0;
      sclk_d = 1'b0;
      if (en) begin
         cnt_d  = wrap ? '0 : cnt_q + PW'(1);
         sclk_d = wrap ? ~sclk_q : sclk_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

   assign rise = wrap && !sclk_q;
   assign fall = wrap && sclk_q;
   assign sclk = sclk_q;

endmodule

// File: rtl/dac_spi_ctrl.sv
// DAC configuration controller: runs the power-up reset sequence, then
// serialises single-byte register reads/writes over 4-wire SPI.
module dac_spi_ctrl
   import dac_spi_ctrl_pkg::*;
#(
   parameter int PRESCALE     = 4,
   parameter int RESET_CYCLES = 64,
   parameter int RESET_WAIT   = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic       cmd_read,
   input  logic [4:0] cmd_addr,
   input  logic [7:0] cmd_wdata,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   input  logic       reset_req,
   output logic       init_done,
   output logic       dac_reset,
   output logic       dac_csb,
   output logic       dac_sclk,
   output logic       dac_sdio,
   input  logic       dac_sdo
);

   localparam int            CW      = cnt_width(max3(PRESCALE, RESET_CYCLES, RESET_WAIT));
   localparam logic [CW-1:0] RC_LAST = CW'(RESET_CYCLES - 1);
   localparam logic [CW-1:0] RW_LAST = CW'(RESET_WAIT - 1);
   localparam logic [CW-1:0] PS_LAST = CW'(PRESCALE - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    bit_q, bit_d;
   logic [15:0]   tx_q, tx_d;
   logic [7:0]    rx_q, rx_d;
   logic          rd_q, rd_d;
   logic          dac_reset_q, dac_reset_d;
   logic          csb_q, csb_d;
   logic          sdio_q, sdio_d;
   logic          cmd_ready_q, cmd_ready_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [7:0]    rsp_rdata_q, rsp_rdata_d;
   logic          init_done_q, init_done_d;
   logic [15:0]   cmd_word;
   logic          ph_rise, ph_fall;

   spi_phase_gen #(.PRESCALE(PRESCALE)) u_phase (
      .clk  (clk),
      .rst  (rst),
      .en   (state_q == ST_SHIFT),
      .rise (ph_rise),
      .fall (ph_fall),
      .sclk (dac_sclk)
   );

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      bit_d       = bit_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      rd_d        = rd_q;
      dac_reset_d = dac_reset_q;
      csb_d       = csb_q;
      sdio_d      = sdio_q;
      cmd_ready_d = cmd_ready_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      init_done_d = init_done_q;
      cmd_word    = build_cmd_word(cmd_read, cmd_addr, cmd_wdata);

      unique case (state_q)
         ST_RST_ASSERT: begin
            if (cnt_q == RC_LAST) begin
               state_d     = ST_RST_WAIT;
               cnt_d       = '0;
               dac_reset_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_RST_WAIT: begin
            if (cnt_q == RW_LAST) begin
               state_d     = ST_IDLE;
               cnt_d       = '0;
               cmd_ready_d = 1'b1;
               init_done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_IDLE: begin
            // A pending hard-reset request takes priority over a command.
            if (reset_req) begin
               state_d     = ST_RST_ASSERT;
               cnt_d       = '0;
               dac_reset_d = 1'b1;
               cmd_ready_d = 1'b0;
               init_done_d = 1'b0;
            end else if (cmd_valid && cmd_ready_q) begin
               state_d     = ST_SHIFT;
               cmd_ready_d = 1'b0;
               csb_d       = 1'b0;
               tx_d        = cmd_word;
               sdio_d      = cmd_word[15];
               bit_d       = 4'd15;
               rd_d        = cmd_read;
               rx_d        = '0;
            end
         end
         ST_SHIFT: begin
            if (ph_rise && (bit_q <= 4'd7)) begin
               rx_d = {rx_q[6:0], dac_sdo};
            end
            if (ph_fall) begin
               if (bit_q == 4'd0) begin
                  state_d = ST_HOLD;
                  cnt_d   = '0;
               end else begin
                  bit_d  = bit_q - 4'd1;
                  tx_d   = tx_q << 1;
                  sdio_d = tx_q[14];
               end
            end
         end
         ST_HOLD: begin
            if (cnt_q == PS_LAST) begin
               state_d     = ST_GAP;
               cnt_d       = '0;
               csb_d       = 1'b1;
               sdio_d      = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_rdata_d = (rd_q == CMD_READ) ? rx_q : 8'h00;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_GAP: begin
            if (cnt_q == PS_LAST) begin
               state_d     = ST_IDLE;
               cnt_d       = '0;
               cmd_ready_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ST_RST_ASSERT;
      endcase
   end

   // NOTE: state updates use non-blocking assignments; reset is synchronous.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RST_ASSERT;
         cnt_q       <= '0;
         bit_q       <= '0;
         tx_q        <= '0;
         rx_q        <= '0;
         rd_q        <= 1'b0;
         dac_reset_q <= 1'b1;
         csb_q       <= 1'b1;
         sdio_q      <= 1'b0;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_q       <= bit_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         rd_q        <= rd_d;
         dac_reset_q <= dac_reset_d;
         csb_q       <= csb_d;
         sdio_q      <= sdio_d;
         cmd_ready_q <= cmd_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         init_done_q <= init_done_d;
      end
   end

   assign cmd_ready = cmd_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign init_done = init_done_q;
   assign dac_reset = dac_reset_q;
   assign dac_csb   = csb_q;
   assign dac_sdio  = sdio_q;

endmodule

// File: tb/tb_dac_spi_ctrl.sv
// Scoreboard bench for dac_spi_ctrl with PRESCALE=2, RESET_CYCLES=4, RESET_WAIT=8
// and a behavioural DAC that captures MOSI and drives a read byte on SDO.
module tb_dac_spi_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_read;
   logic [4:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       reset_req;
   logic       init_done;
   logic       dac_reset;
   logic       dac_csb;
   logic       dac_sclk;
   logic       dac_sdio;
   logic       dac_sdo = 1'b0;

   typedef struct packed {
      logic [15:0] word;
      logic [7:0]  rdata;
   } exp_t;

   exp_t        sb_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = 0;
   logic [15:0] mosi_sr = '0;
   int          rise_cnt = 0;
   logic [7:0]  sdo_byte = 8'h00;

   dac_spi_ctrl #(.PRESCALE(2), .RESET_CYCLES(4), .RESET_WAIT(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_read  (cmd_read),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .reset_req (reset_req),
      .init_done (init_done),
      .dac_reset (dac_reset),
      .dac_csb   (dac_csb),
      .dac_sclk  (dac_sclk),
      .dac_sdio  (dac_sdio),
      .dac_sdo   (dac_sdo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // DAC model: shift MOSI on each SCLK rise, restart on CSB fall.
   always @(posedge dac_sclk or negedge dac_csb) begin
      if (dac_sclk) begin
         mosi_sr  = {mosi_sr[14:0], dac_sdio};
         rise_cnt = rise_cnt + 1;
      end else begin
         mosi_sr  = '0;
         rise_cnt = 0;
      end
   end

   // After the 8th rise the DAC presents the read byte, one bit per SCLK fall.
   always @(negedge dac_sclk) begin
      if (rise_cnt >= 8 && rise_cnt < 16) dac_sdo = sdo_byte[3'(15 - rise_cnt)];
   end

   // Response scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (rsp_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_rsp: rsp_valid with rdata %h at cycle %0d, none expected", rsp_rdata, cyc);
         end else begin
            e = sb_q.pop_front();
            n_vec++;
            if (rsp_rdata !== e.rdata) begin
               n_err++;
               $display("FAIL rsp_rdata: got %h expected %h", rsp_rdata, e.rdata);
            end
            n_vec++;
            if (mosi_sr !== e.word || rise_cnt != 16) begin
               n_err++;
               $display("FAIL mosi_word: got %h (%0d rises) expected %h (16 rises)", mosi_sr, rise_cnt, e.word);
            end
         end
      end
   end

   task automatic push_exp(input logic rd, input logic [4:0] a, input logic [7:0] wd, input logic [7:0] sdo);
      exp_t e;
      e.word  = {rd, 2'b00, a, (rd ? 8'h00 : wd)};
      e.rdata = rd ? sdo : 8'h00;
      sb_q.push_back(e);
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (cmd_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Observes one transaction from cycle t0+1 until cmd_ready returns.
   task automatic observe_txn(input int t0, output int csb_low, output int rsp_at,
                              output int rdy_at, output int n_rsp);
      csb_low = 0; rsp_at = -1; rdy_at = -1; n_rsp = 0;
      for (int k = 0; k < 300; k++) begin
         if (dac_csb === 1'b0) csb_low++;
         if (rsp_valid === 1'b1) begin
            n_rsp++;
            if (rsp_at < 0) rsp_at = cyc - t0;
         end
         if (cmd_ready === 1'b1) begin
            rdy_at = cyc - t0;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Observes a reset sequence starting at its first dac_reset=1 cycle.
   task automatic observe_reset_seq(output int hi, output int lo, output bit pins_ok);
      hi = 0; lo = 0; pins_ok = 1'b1;
      for (int k = 0; k < 100; k++) begin
         if (dac_csb !== 1'b1 || dac_sclk !== 1'b0 || init_done !== cmd_ready) pins_ok = 1'b0;
         if (cmd_ready === 1'b1) break;
         if (dac_reset === 1'b1) begin
            if (lo != 0) pins_ok = 1'b0;
            hi++;
         end else begin
            lo++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      logic [6:0] got, exp;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      // {dac_reset, cmd_ready, init_done, dac_csb, dac_sclk, dac_sdio, rsp_valid}
      got = {dac_reset, cmd_ready, init_done, dac_csb, dac_sclk, dac_sdio, rsp_valid};
      n_vec++;
      if (got !== 7'b1001000) begin
         n_err++;
         $display("FAIL reset_outputs: got %b expected %b", got, 7'b1001000);
      end
      n_vec++;
      if (rsp_rdata !== 8'h00) begin
         n_err++;
         $display("FAIL reset_rdata: got %h expected 00", rsp_rdata);
      end
      rst = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         exp = {(k < 4), (k == 12), (k == 12), 4'b1000};
         got = {dac_reset, cmd_ready, init_done, dac_csb, dac_sclk, dac_sdio, rsp_valid};
         n_vec++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL reset_seq_c%0d: got %b expected %b", k, got, exp);
         end
      end
   endtask

   task automatic run_single(input string name, input logic rd, input logic [4:0] a,
                             input logic [7:0] wd, input logic [7:0] sdo);
      bit ok;
      int t0, csb_low, rsp_at, rdy_at, n_rsp;
      wait_ready(ok);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s_ready_timeout: cmd_ready got %b expected 1", name, cmd_ready);
      end
      sdo_byte  = sdo;
      cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd;
      push_exp(rd, a, wd, sdo);
      t0 = cyc;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_addr = ~a; cmd_wdata = ~wd; cmd_read = ~rd;
      n_vec++;
      if ({cmd_ready, dac_csb} !== 2'b00) begin
         n_err++;
         $display("FAIL %s_start: {cmd_ready,csb} got %b expected 00", name, {cmd_ready, dac_csb});
      end
      observe_txn(t0, csb_low, rsp_at, rdy_at, n_rsp);
      n_vec++;
      if (csb_low != 66) begin
         n_err++;
         $display("FAIL %s_csb_low: got %0d cycles expected 66", name, csb_low);
      end
      n_vec++;
      if (rsp_at != 67 || n_rsp != 1) begin
         n_err++;
         $display("FAIL %s_rsp_timing: got T+%0d x%0d expected T+67 x1", name, rsp_at, n_rsp);
      end
      n_vec++;
      if (rdy_at != 69) begin
         n_err++;
         $display("FAIL %s_ready_back: got T+%0d expected T+69", name, rdy_at);
      end
   endtask

   task automatic test_write();
      run_single("write", 1'b0, 5'h02, 8'hA5, 8'hFF);
   endtask

   task automatic test_read();
      run_single("read", 1'b1, 5'h1F, 8'h77, 8'h3C);
   endtask

   task automatic test_back_to_back();
      bit ok;
      int rise1, fall2, n_rsp, n_fall;
      logic prev;
      wait_ready(ok);
      sdo_byte  = 8'h81;
      cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 5'h11; cmd_wdata = 8'h3C;
      push_exp(1'b0, 5'h11, 8'h3C, 8'h81);
      @(negedge clk);
      cmd_addr = 5'h12; cmd_wdata = 8'hC3;
      push_exp(1'b0, 5'h12, 8'hC3, 8'h81);
      rise1 = -1; fall2 = -1; n_rsp = 0; n_fall = 1; prev = dac_csb;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) n_rsp++;
         if (prev === 1'b0 && dac_csb === 1'b1 && rise1 < 0) rise1 = cyc;
         if (prev === 1'b1 && dac_csb === 1'b0) begin
            n_fall++;
            if (fall2 < 0) fall2 = cyc;
            cmd_valid = 1'b0;
         end
         prev = dac_csb;
         if (n_rsp == 2 && cmd_ready === 1'b1) break;
      end
      cmd_valid = 1'b0;
      n_vec++;
      if (rise1 < 0 || fall2 < 0 || fall2 - rise1 != 3) begin
         n_err++;
         $display("FAIL b2b_gap: got rise %0d fall %0d expected fall = rise + 3", rise1, fall2);
      end
      n_vec++;
      if (n_rsp != 2 || n_fall != 2) begin
         n_err++;
         $display("FAIL b2b_count: got %0d rsp %0d csb falls expected 2 and 2", n_rsp, n_fall);
      end
   endtask

   task automatic test_reset_req();
      bit ok, pins_ok;
      int hi, lo, t0, csb_low, rsp_at, rdy_at, n_rsp;
      wait_ready(ok);
      sdo_byte  = 8'h00;
      reset_req = 1'b1;
      cmd_valid = 1'b1; cmd_read = 1'b0; cmd_addr = 5'h05; cmd_wdata = 8'h5A;
      @(negedge clk);
      reset_req = 1'b0;
      n_vec++;
      if ({dac_reset, dac_csb, cmd_ready, init_done} !== 4'b1100) begin
         n_err++;
         $display("FAIL rreq_enter: {dac_reset,csb,ready,init} got %b expected 1100",
                  {dac_reset, dac_csb, cmd_ready, init_done});
      end
      observe_reset_seq(hi, lo, pins_ok);
      n_vec++;
      if (hi != 4 || lo != 8) begin
         n_err++;
         $display("FAIL rreq_seq: got reset %0d wait %0d expected 4 and 8", hi, lo);
      end
      n_vec++;
      if (!pins_ok) begin
         n_err++;
         $display("FAIL rreq_pins: got pins_ok %b expected 1", pins_ok);
      end
      push_exp(1'b0, 5'h05, 8'h5A, 8'h00);
      t0 = cyc;
      @(negedge clk);
      cmd_valid = 1'b0;
      observe_txn(t0, csb_low, rsp_at, rdy_at, n_rsp);
      n_vec++;
      if (rsp_at != 67 || n_rsp != 1 || csb_low != 66) begin
         n_err++;
         $display("FAIL rreq_cmd: got rsp T+%0d x%0d csb_low %0d expected T+67 x1 66", rsp_at, n_rsp, csb_low);
      end
   endtask

   task automatic test_rst_mid();
      bit ok, pins_ok;
      int hi, lo;
      logic [6:0] got;
      wait_ready(ok);
      sdo_byte  = 8'hC3;
      cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 5'h0A; cmd_wdata = 8'h00;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (26) @(negedge clk);
      n_vec++;
      if ({dac_csb, dac_sclk} !== 2'b01) begin
         n_err++;
         $display("FAIL rst_mid_active: {csb,sclk} got %b expected 01", {dac_csb, dac_sclk});
      end
      rst = 1'b1;
      @(negedge clk);
      got = {dac_csb, dac_sclk, rsp_valid, dac_reset, cmd_ready, init_done, dac_sdio};
      n_vec++;
      if (got !== 7'b1001000) begin
         n_err++;
         $display("FAIL rst_mid_outputs: got %b expected %b", got, 7'b1001000);
      end
      rst = 1'b0;
      observe_reset_seq(hi, lo, pins_ok);
      n_vec++;
      if (hi != 4 || lo != 8 || !pins_ok) begin
         n_err++;
         $display("FAIL rst_mid_seq: got reset %0d wait %0d pins %b expected 4 8 1", hi, lo, pins_ok);
      end
      repeat (10) @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; reset_req = 1'b0;
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_reset_req();
      test_rst_mid();
      n_vec++;
      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL sb_drain: got %0d pending responses expected 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation time limit expected completion");
      $fatal(1, "watchdog");
   end

endmodule
